aes256_unloading: RTL
=====================

Name: aes256_unloading

Overview:
- Initiator/reader side of the aes256_loading core interface.
- Takes a 256-bit master key and 128-bit plaintext blocks from an upstream valid/ready source.
- Sequences key expansion on the core, then issues 16 byte requests per block and collects the 8-bit result stream.
- Reassembles the bytes into a 128-bit ciphertext word for a downstream valid/ready sink.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles waiting on pi_key_ready or pi_next_val_ready before an abort.
- BYTES_PER_BLK, 16: bytes collected per block. Fixed; other values are unsupported.

Ports:
- clk  in  1  single clock, rising edge
- pi_rst_n  in  1  synchronous active-low reset
- pi_key_load  in  1  one-cycle pulse: capture pi_key and start key expansion
- pi_key  in  256  master key
- po_key_valid  out  1  expanded key ready in core; blocks may be accepted
- pi_blk_valid  in  1  plaintext block valid
- pi_blk  in  128  plaintext block
- po_blk_ready  out  1  block accept
- po_key_expand_start  out  1  to core key_expand_start
- po_master_key  out  256  to core master_key (registered)
- pi_key_ready  in  1  from core key_ready
- po_next_val_req  out  1  to core next_val_req
- po_data  out  128  to core data_in (registered block)
- pi_next_val_ready  in  1  from core next_val_ready
- pi_data_byte  in  8  from core data_out
- po_ct_valid  out  1  ciphertext valid
- po_ct  out  128  ciphertext, first received byte in [127:120]
- pi_ct_ready  in  1  downstream accept
- po_err  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset (pi_rst_n=0 at a clk edge): state IDLE, all outputs 0, byte_cnt=0, timer=0. Applies mid-operation; any partial block is discarded.
- All outputs are registered. po_blk_ready=1 exactly in state READY.
- IDLE: on pi_key_load, latch pi_key into po_master_key and go to KSTART.
- KSTART: po_key_expand_start=1 for exactly one cycle, then go to KWAIT.
- KWAIT: on pi_key_ready=1, set po_key_valid=1 and go to READY.
- READY:
  - pi_blk_valid=1: latch pi_blk into po_data, byte_cnt=0, go to REQ.
  - Otherwise, pi_key_load=1: po_key_valid=0, latch new key, go to KSTART.
  - If both are high in the same cycle, the block wins and pi_key_load is dropped.
- REQ: po_next_val_req=1 for exactly one cycle, then go to BWAIT.
- BWAIT: on pi_next_val_ready=1, write pi_data_byte into po_ct[127-8*byte_cnt -: 8].
  - byte_cnt==15: go to OUT.
  - Otherwise: byte_cnt+1, go to REQ.
  - Exactly one request is outstanding at any time.
- OUT: po_ct_valid=1, po_ct stable until pi_ct_ready=1. Then po_ct_valid=0 and go to READY next cycle.
- Ignored inputs:
  - pi_next_val_ready outside BWAIT.
  - pi_key_load outside IDLE/READY.
  - pi_blk_valid outside READY.
- Timer:
  - Counts in KWAIT and BWAIT; reset on every state entry.
  - At TIMEOUT_CYCLES: set po_err=1, po_key_valid=0, go to IDLE.
  - Not active in OUT; downstream backpressure is unbounded.
- byte_cnt is 4 bits and never wraps past 15 within a block.
- Latency:
  - Block accepted at cycle T, core byte latency N≥1 cycles after each req.
  - First req at T+1; byte k arrives at T+1+k(N+1)+N.
  - po_ct_valid rises at T+16(N+1)+1; with N=1 this is T+33.
- Back-to-back operation: after OUT handshake at cycle C, po_blk_ready=1 at C+1.

Test Plan:
- Key load: pulse pi_key_load with key 000102…1e1f -> po_master_key equals key, po_key_expand_start high exactly 1 cycle. Core BFM asserts key_ready 20 cycles later -> po_key_valid=1 next cycle.
- Single block: pt 00112233445566778899aabbccddeeff, BFM returns bytes 8e,a2,b7,ca,51,67,45,bf,ea,fc,49,90,4b,49,60,89 with N=1 -> po_ct=8ea2b7ca516745bfeafc49904b496089, po_ct_valid at T+33, exactly 16 req pulses.
- Backpressure and stray inputs: hold pi_ct_ready=0 for 50 cycles, inject spurious pi_next_val_ready in OUT -> po_ct stable, no extra req, accept on ready. Next block accepted one cycle later.
- Timeout: BFM never answers the 5th req -> po_err=1 after 1024 cycles, state IDLE, po_key_valid=0, po_blk_ready=0.
- Rekey and collision: in READY assert pi_key_load alone -> po_key_valid drops, new po_master_key, expand pulse. Assert pi_key_load with pi_blk_valid together -> block accepted, key unchanged.
- Reset mid-block: pi_rst_n=0 for 1 cycle after byte 7 -> all outputs 0 next cycle. A later key load plus block produces the full correct ciphertext.

Source files
------------

// File: rtl/aes256_unloading.sv
// aes256_unloading: initiator side of the aes256_loading core. Loads the
// master key, runs key expansion, then pulls 16 result bytes per plaintext
// block and hands the reassembled 128-bit ciphertext to a valid/ready sink.
// Ports:
//   clk, pi_rst_n                  clock, synchronous active-low reset
//   pi_key_load, pi_key            key capture pulse and 256-bit master key
//   po_key_valid                   expanded key is resident in the core
//   pi_blk_valid, pi_blk           plaintext block source
//   po_blk_ready                   block accept
//   po_key_expand_start            expansion start pulse to the core
//   po_master_key                  registered master key to the core
//   pi_key_ready                   expansion done from the core
//   po_next_val_req                one-cycle byte request to the core
//   po_data                        registered plaintext block to the core
//   pi_next_val_ready              byte strobe from the core
//   pi_data_byte                   result byte from the core
//   po_ct_valid, po_ct             ciphertext to the sink, first byte on top
//   pi_ct_ready                    sink accept
//   po_err                         sticky timeout flag
module aes256_unloading #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int BYTES_PER_BLK  = 16
) (
  input  logic         clk,
  input  logic         pi_rst_n,
  input  logic         pi_key_load,
  input  logic [255:0] pi_key,
  output logic         po_key_valid,
  input  logic         pi_blk_valid,
  input  logic [127:0] pi_blk,
  output logic         po_blk_ready,
  output logic         po_key_expand_start,
  output logic [255:0] po_master_key,
  input  logic         pi_key_ready,
  output logic         po_next_val_req,
  output logic [127:0] po_data,
  input  logic         pi_next_val_ready,
  input  logic [7:0]   pi_data_byte,
  output logic         po_ct_valid,
  output logic [127:0] po_ct,
  input  logic         pi_ct_ready,
  output logic         po_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] B_LAST = 4'(BYTES_PER_BLK - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KSTART,
    S_KWAIT,
    S_READY,
    S_REQ,
    S_BWAIT,
    S_OUT
  } state_e;

  state_e          state_q, state_d;
  logic [255:0]    key_q, key_d;
  logic [127:0]    data_q, data_d;
  logic [127:0]    ct_q, ct_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            kv_q, kv_d;
  logic            err_q, err_d;
  logic            ks_q, ks_d;
  logic            req_q, req_d;
  logic            br_q, br_d;
  logic            ctv_q, ctv_d;
  logic [6:0]      ct_lsb;

  // Byte k lands at bits [127-8k -: 8]; its lsb is 8*(15-k) = {~k, 3'b0}.
  assign ct_lsb = {~cnt_q, 3'b000};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    data_d  = data_q;
    ct_d    = ct_q;
    cnt_d   = cnt_q;
    timer_d = '0;
    kv_d    = kv_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (pi_key_load) begin
          key_d   = pi_key;
          state_d = S_KSTART;
        end
      end
      S_KSTART: state_d = S_KWAIT;
      S_KWAIT: begin
        if (pi_key_ready) begin
          kv_d    = 1'b1;
          state_d = S_READY;
        end else if (timer_q == T_LAST) begin
          err_d   = 1'b1;
          kv_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_READY: begin
        // A block arriving with a key load wins; the load is dropped.
        if (pi_blk_valid) begin
          data_d  = pi_blk;
          cnt_d   = '0;
          state_d = S_REQ;
        end else if (pi_key_load) begin
          kv_d    = 1'b0;
          key_d   = pi_key;
          state_d = S_KSTART;
        end
      end
      S_REQ: state_d = S_BWAIT;
      S_BWAIT: begin
        if (pi_next_val_ready) begin
          ct_d[ct_lsb +: 8] = pi_data_byte;
          if (cnt_q == B_LAST) begin
            state_d = S_OUT;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            state_d = S_REQ;
          end
        end else if (timer_q == T_LAST) begin
          err_d   = 1'b1;
          kv_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_OUT: begin
        if (pi_ct_ready) state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes and handshakes are registered images of the next state.
    ks_d  = (state_d == S_KSTART);
    req_d = (state_d == S_REQ);
    br_d  = (state_d == S_READY);
    ctv_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk) begin
    if (!pi_rst_n) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      data_q  <= '0;
      ct_q    <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      kv_q    <= 1'b0;
      err_q   <= 1'b0;
      ks_q    <= 1'b0;
      req_q   <= 1'b0;
      br_q    <= 1'b0;
      ctv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      data_q  <= data_d;
      ct_q    <= ct_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      kv_q    <= kv_d;
      err_q   <= err_d;
      ks_q    <= ks_d;
      req_q   <= req_d;
      br_q    <= br_d;
      ctv_q   <= ctv_d;
    end
  end

  assign po_key_valid        = kv_q;
  assign po_blk_ready        = br_q;
  assign po_key_expand_start = ks_q;
  assign po_master_key       = key_q;
  assign po_next_val_req     = req_q;
  assign po_data             = data_q;
  assign po_ct_valid         = ctv_q;
  assign po_ct               = ct_q;
  assign po_err              = err_q;

endmodule
